// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: datapath width, writeback source encodings
// and load funct3 encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it according to funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        // Misaligned halfwords fall back to the containing halfword.
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
            F3_LW:   data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extension, writeback select, register
// file write port and a retired-instruction counter.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [DATA_W-1:0]    mem_alu_result,
    input  logic [DATA_W-1:0]    mem_read_data,
    input  logic [DATA_W-1:0]    mem_pc_plus4,
    output logic                 wb_valid,
    output logic                 regwrite,
    output logic [4:0]           rd,
    output logic [DATA_W-1:0]    write_data,
    output logic [INSTRET_W-1:0] instret
);

    logic                 valid_q, valid_d;
    logic                 regwrite_q, regwrite_d;
    logic [4:0]           rd_q, rd_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [DATA_W-1:0]    load_data;
    logic [DATA_W-1:0]    wb_data;
    logic                 retire;

    load_extend u_load_extend (
        .word_i   (mem_read_data),
        .off_i    (mem_alu_result[1:0]),
        .funct3_i (mem_funct3),
        .data_o   (load_data)
    );

    // Reserved select 11 behaves like the ALU path.
    always_comb begin
        case (mem_wb_sel)
            WB_SEL_ALU: wb_data = mem_alu_result;
            WB_SEL_MEM: wb_data = load_data;
            WB_SEL_PC4: wb_data = mem_pc_plus4;
            default:    wb_data = mem_alu_result;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            rd_d       = '0;
            wdata_d    = '0;
        end else if (!stall) begin
            valid_d    = mem_valid;
            regwrite_d = mem_valid & mem_regwrite & (mem_rd != 5'd0);
            rd_d       = mem_rd;
            wdata_d    = wb_data;
        end
    end

    // A flush pushes the WB instruction out even when the pipe is stalled.
    assign retire    = valid_q & (~stall | flush);
    assign instret_d = instret_q + INSTRET_W'(retire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            instret_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            instret_q  <= instret_d;
        end
    end

    assign wb_valid   = valid_q;
    assign regwrite   = regwrite_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign instret    = instret_q;

endmodule
